// File: rtl/cpu_datapath_if.sv
// cpu_datapath_if: bundles the register-bank, operand-select and ALU
// signals of the execution datapath slice.
//   master : control side (drives enables, addresses, data, selects, opcode)
//   slave  : datapath side (returns read data, ALU result and flags)
// Parameter WIDTH sets the datapath and register width.
interface cpu_datapath_if #(
  parameter int WIDTH = 32
);
  logic             rd_en1;
  logic             rd_en2;
  logic [3:0]       rd_addr1;
  logic [3:0]       rd_addr2;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             sel_a;
  logic             sel_b;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] imm_in;
  logic [3:0]       alu_op;
  logic             alu_en;
  logic [WIDTH-1:0] alu_out;
  logic             zero_flag;
  logic             carry_flag;

  modport master (
    output rd_en1, rd_en2, rd_addr1, rd_addr2,
    output wr_en, wr_addr, wr_data,
    output sel_a, sel_b, pc_in, imm_in, alu_op, alu_en,
    input  rd_data1, rd_data2, alu_out, zero_flag, carry_flag
  );

  modport slave (
    input  rd_en1, rd_en2, rd_addr1, rd_addr2,
    input  wr_en, wr_addr, wr_data,
    input  sel_a, sel_b, pc_in, imm_in, alu_op, alu_en,
    output rd_data1, rd_data2, alu_out, zero_flag, carry_flag
  );
endinterface

// File: rtl/cpu_datapath.sv
// cpu_datapath: execution datapath slice of the multicycle RISC CPU.
// 16 x WIDTH register bank (two registered read ports, one write port),
// two combinational operand muxes and a 4-bit-opcode ALU whose result and
// zero/carry flags are registered when alu_en is high.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears all state
//   bus  - cpu_datapath_if.slave (read/write ports, selects, ALU control,
//          rd_data1/2, alu_out, zero_flag, carry_flag)
// Build option: define RF_BYPASS_EN for write-first forwarding on the read
// ports; left undefined the bank is read-first (old contents returned).
module cpu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  cpu_datapath_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs_r [16];
  logic [WIDTH-1:0] rd_data1_r;
  logic [WIDTH-1:0] rd_data2_r;
  logic [WIDTH-1:0] alu_out_r;
  logic             zero_r;
  logic             carry_r;

  logic [WIDTH-1:0] rd_next1_s;
  logic [WIDTH-1:0] rd_next2_s;
  logic [WIDTH-1:0] op1_s;
  logic [WIDTH-1:0] op2_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   inc_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             carry_s;

  // Population count of a WIDTH-bit word, zero-extended to WIDTH bits.
  function automatic logic [WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] cnt;
    cnt = ZERO_W;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{(WIDTH-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Register bank write port; R0 is an ordinary register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= ZERO_W;
      end
    end else if (bus.wr_en) begin
      regs_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Value each read port would capture on this edge.
`ifdef RF_BYPASS_EN
  // Write-first: a same-edge write to the addressed register is forwarded.
  always_comb begin
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr1)) begin
      rd_next1_s = bus.wr_data;
    end else begin
      rd_next1_s = regs_r[bus.rd_addr1];
    end
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr2)) begin
      rd_next2_s = bus.wr_data;
    end else begin
      rd_next2_s = regs_r[bus.rd_addr2];
    end
  end
`else
  // Read-first: the array still holds the pre-write value at the edge.
  always_comb begin
    rd_next1_s = regs_r[bus.rd_addr1];
    rd_next2_s = regs_r[bus.rd_addr2];
  end
`endif

  // Registered read ports; data holds while the enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data1_r <= ZERO_W;
      rd_data2_r <= ZERO_W;
    end else begin
      if (bus.rd_en1) begin
        rd_data1_r <= rd_next1_s;
      end
      if (bus.rd_en2) begin
        rd_data2_r <= rd_next2_s;
      end
    end
  end

  // Operand multiplexers.
  always_comb begin
    op1_s = bus.sel_a ? bus.pc_in  : rd_data1_r;
    op2_s = bus.sel_b ? bus.imm_in : rd_data2_r;
  end

  // ALU core; carry is bit WIDTH of the widened sum, or the unsigned borrow.
  always_comb begin
    sum_s     = {1'b0, op1_s} + {1'b0, op2_s};
    inc_s     = {1'b0, op1_s} + {1'b0, ONE_W};
    alu_res_s = ZERO_W;
    carry_s   = 1'b0;
    case (bus.alu_op)
      4'd0: begin
        alu_res_s = sum_s[WIDTH-1:0];
        carry_s   = sum_s[WIDTH];
      end
      4'd1: begin
        alu_res_s = op1_s - op2_s;
        carry_s   = (op1_s < op2_s);
      end
      4'd2:  alu_res_s = op1_s & op2_s;
      4'd3:  alu_res_s = op1_s | op2_s;
      4'd4:  alu_res_s = op1_s ^ op2_s;
      4'd5:  alu_res_s = ~op1_s;
      4'd6:  alu_res_s = op1_s << op2_s[4:0];
      4'd7:  alu_res_s = $unsigned($signed(op1_s) >>> op2_s[4:0]);
      4'd8:  alu_res_s = op1_s >> op2_s[4:0];
      4'd9: begin
        alu_res_s = inc_s[WIDTH-1:0];
        carry_s   = inc_s[WIDTH];
      end
      4'd10: begin
        alu_res_s = op1_s - ONE_W;
        carry_s   = (op1_s == ZERO_W);
      end
      4'd11: alu_res_s = popcount(op1_s);
      default: begin
        alu_res_s = ZERO_W;
        carry_s   = 1'b0;
      end
    endcase
  end

  // Result and flag registers; hold while alu_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out_r <= ZERO_W;
      zero_r    <= 1'b0;
      carry_r   <= 1'b0;
    end else if (bus.alu_en) begin
      alu_out_r <= alu_res_s;
      zero_r    <= (alu_res_s == ZERO_W);
      carry_r   <= carry_s;
    end
  end

  assign bus.rd_data1   = rd_data1_r;
  assign bus.rd_data2   = rd_data2_r;
  assign bus.alu_out    = alu_out_r;
  assign bus.zero_flag  = zero_r;
  assign bus.carry_flag = carry_r;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed plus randomized bench for cpu_datapath with a
// behavioural register-file/ALU model. Honours RF_BYPASS_EN for the
// same-edge read/write expectation.
module tb_cpu_datapath;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  cpu_datapath_if #(.WIDTH(32)) bus ();

  cpu_datapath #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_regs [16];
  logic [31:0] m_rd1, m_rd2, m_alu;
  logic        m_z, m_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_rd1 = 32'd0; m_rd2 = 32'd0; m_alu = 32'd0; m_z = 1'b0; m_c = 1'b0;
  endtask

  // Reference ALU written from the operation table.
  task automatic alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c);
    longint unsigned s;
    int sh;
    sh = int'(b % 32);
    r = 32'd0;
    c = 1'b0;
    case (op)
      4'd0: begin s = longint'(a) + longint'(b); r = s[31:0]; c = s[32]; end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << sh;
      4'd7: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8: r = a >> sh;
      4'd9: begin r = a + 32'd1; c = (a == 32'hFFFF_FFFF); end
      4'd10: begin r = a - 32'd1; c = (a == 32'd0); end
      4'd11: r = 32'($countones(a));
      default: r = 32'd0;
    endcase
  endtask

  // One clock edge: predict from current inputs, advance, compare all outputs.
  task automatic cycle(input string tag);
    logic [31:0] op1, op2, r, n1, n2;
    logic c;
    op1 = bus.sel_a ? bus.pc_in  : m_rd1;
    op2 = bus.sel_b ? bus.imm_in : m_rd2;
    alu_ref(bus.alu_op, op1, op2, r, c);
    n1 = m_rd1;
    n2 = m_rd2;
    if (bus.rd_en1)
      n1 = (BYPASS && bus.wr_en && bus.wr_addr == bus.rd_addr1) ? bus.wr_data : m_regs[bus.rd_addr1];
    if (bus.rd_en2)
      n2 = (BYPASS && bus.wr_en && bus.wr_addr == bus.rd_addr2) ? bus.wr_data : m_regs[bus.rd_addr2];
    if (bus.alu_en) begin
      m_alu = r; m_c = c; m_z = (r == 32'd0);
    end
    if (bus.wr_en) m_regs[bus.wr_addr] = bus.wr_data;
    m_rd1 = n1;
    m_rd2 = n2;
    @(posedge clk);
    #1;
    check({tag, ".rd1"},   bus.rd_data1,   m_rd1);
    check({tag, ".rd2"},   bus.rd_data2,   m_rd2);
    check({tag, ".alu"},   bus.alu_out,    m_alu);
    check({tag, ".zero"},  {31'd0, bus.zero_flag},  {31'd0, m_z});
    check({tag, ".carry"}, {31'd0, bus.carry_flag}, {31'd0, m_c});
  endtask

  task automatic idle();
    bus.rd_en1 = 1'b0; bus.rd_en2 = 1'b0; bus.rd_addr1 = 4'd0; bus.rd_addr2 = 4'd0;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 32'd0;
    bus.sel_a = 1'b0; bus.sel_b = 1'b0; bus.pc_in = 32'd0; bus.imm_in = 32'd0;
    bus.alu_op = 4'd0; bus.alu_en = 1'b0;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d);
    idle(); bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    cycle("write");
  endtask

  task automatic alu_imm(input string tag, input logic [3:0] op, input logic [31:0] pc, input logic [31:0] imm);
    idle(); bus.sel_a = 1'b1; bus.sel_b = 1'b1; bus.pc_in = pc; bus.imm_in = imm;
    bus.alu_op = op; bus.alu_en = 1'b1;
    cycle(tag);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();
    model_reset();
    rst = 1'b1;
    #12;
    check("reset.rd1",   bus.rd_data1, 32'd0);
    check("reset.rd2",   bus.rd_data2, 32'd0);
    check("reset.alu",   bus.alu_out,  32'd0);
    check("reset.zero",  {31'd0, bus.zero_flag},  32'd0);
    check("reset.carry", {31'd0, bus.carry_flag}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-sequence: load R3 and a non-zero result, then pulse rst between edges.
    write(4'd3, 32'h0000_1234);
    idle(); bus.rd_en1 = 1'b1; bus.rd_addr1 = 4'd3; cycle("rd_r3");
    check("rd_r3.val", bus.rd_data1, 32'h0000_1234);
    idle(); bus.sel_b = 1'b1; bus.imm_in = 32'd0; bus.alu_en = 1'b1; cycle("add_r3");
    check("add_r3.val", bus.alu_out, 32'h0000_1234);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst.rd1",   bus.rd_data1, 32'd0);
    check("async_rst.alu",   bus.alu_out,  32'd0);
    check("async_rst.zero",  {31'd0, bus.zero_flag},  32'd0);
    check("async_rst.carry", {31'd0, bus.carry_flag}, 32'd0);
    #1 rst = 1'b0;
    idle(); bus.rd_en1 = 1'b1; bus.rd_addr1 = 4'd3; cycle("rd_r3_after_rst");
    check("rd_r3_after_rst.val", bus.rd_data1, 32'd0);

    // Register-to-register ADD.
    write(4'd5, 32'h0000_00FF);
    write(4'd6, 32'h0000_0001);
    idle(); bus.rd_en1 = 1'b1; bus.rd_addr1 = 4'd5; bus.rd_en2 = 1'b1; bus.rd_addr2 = 4'd6;
    cycle("rd_r5_r6");
    idle(); bus.alu_op = 4'd0; bus.alu_en = 1'b1; cycle("add_regs");
    check("add_regs.val", bus.alu_out, 32'h0000_0100);
    check("add_regs.zero", {31'd0, bus.zero_flag}, 32'd0);
    check("add_regs.carry", {31'd0, bus.carry_flag}, 32'd0);

    // PC/immediate path and borrow/zero cases.
    alu_imm("add_pc_imm", 4'd0, 32'h0000_0040, 32'hFFFF_FFF0);
    check("add_pc_imm.val", bus.alu_out, 32'h0000_0030);
    check("add_pc_imm.carry", {31'd0, bus.carry_flag}, 32'd1);
    alu_imm("sub_eq", 4'd1, 32'd5, 32'd5);
    check("sub_eq.val", bus.alu_out, 32'd0);
    check("sub_eq.zero", {31'd0, bus.zero_flag}, 32'd1);
    check("sub_eq.carry", {31'd0, bus.carry_flag}, 32'd0);
    alu_imm("sub_borrow", 4'd1, 32'd3, 32'd5);
    check("sub_borrow.val", bus.alu_out, 32'hFFFF_FFFE);
    check("sub_borrow.carry", {31'd0, bus.carry_flag}, 32'd1);

    // Shifts, popcount, reserved opcode, INC/DEC wrap.
    alu_imm("sra", 4'd7, 32'h8000_0000, 32'd4);
    check("sra.val", bus.alu_out, 32'hF800_0000);
    alu_imm("srl", 4'd8, 32'h8000_0000, 32'd4);
    check("srl.val", bus.alu_out, 32'h0800_0000);
    alu_imm("ham", 4'd11, 32'hF0F0_0001, 32'd0);
    check("ham.val", bus.alu_out, 32'd9);
    alu_imm("rsvd13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
    check("rsvd13.val", bus.alu_out, 32'd0);
    check("rsvd13.zero", {31'd0, bus.zero_flag}, 32'd1);
    alu_imm("inc_wrap", 4'd9, 32'hFFFF_FFFF, 32'd0);
    check("inc_wrap.carry", {31'd0, bus.carry_flag}, 32'd1);
    alu_imm("dec_wrap", 4'd10, 32'd0, 32'd0);
    check("dec_wrap.val", bus.alu_out, 32'hFFFF_FFFF);

    // alu_en low holds result and flags.
    idle(); bus.sel_a = 1'b1; bus.pc_in = 32'd77; bus.alu_op = 4'd9; cycle("alu_hold");
    check("alu_hold.val", bus.alu_out, 32'hFFFF_FFFF);

    // Same-edge read and write of R7 on both ports.
    idle(); bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 32'hDEAD_BEEF;
    bus.rd_en1 = 1'b1; bus.rd_addr1 = 4'd7; bus.rd_en2 = 1'b1; bus.rd_addr2 = 4'd7;
    cycle("rw_same");
    check("rw_same.val", bus.rd_data1, BYPASS ? 32'hDEAD_BEEF : 32'd0);
    idle(); bus.rd_en1 = 1'b1; bus.rd_addr1 = 4'd7; cycle("rw_next");
    check("rw_next.val", bus.rd_data1, 32'hDEAD_BEEF);
    idle(); cycle("rd_hold");
    check("rd_hold.val", bus.rd_data1, 32'hDEAD_BEEF);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bus.rd_en1   = 1'($urandom_range(0, 1));
      bus.rd_en2   = 1'($urandom_range(0, 1));
      bus.rd_addr1 = 4'($urandom_range(0, 15));
      bus.rd_addr2 = 4'($urandom_range(0, 15));
      bus.wr_en    = 1'($urandom_range(0, 1));
      bus.wr_addr  = 4'($urandom_range(0, 15));
      bus.wr_data  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      bus.sel_a    = 1'($urandom_range(0, 1));
      bus.sel_b    = 1'($urandom_range(0, 1));
      bus.pc_in    = 32'($urandom);
      bus.imm_in   = ($urandom_range(0, 3) == 0) ? bus.pc_in : 32'($urandom);
      bus.alu_op   = 4'($urandom_range(0, 15));
      bus.alu_en   = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Execution datapath slice of the multicycle RISC CPU: a 16 x 32-bit register bank with two synchronous read ports and one write port, two 2:1 operand multiplexers, and a 4-bit-opcode ALU with a registered result and flags. The CPU control FSM sequences it through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK; this block holds no instruction-level state of its own.

## Interface
- WIDTH, 32, datapath and register width
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rd_en1 / rd_en2  input  1  read-port enables
- rd_addr1 / rd_addr2  input  4  read-port register addresses
- rd_data1 / rd_data2  output  WIDTH  registered read data
- wr_en  input  1  write enable
- wr_addr  input  4  write register address
- wr_data  input  WIDTH  write data
- sel_a  input  1  operand-1 select: 0 = rd_data1, 1 = pc_in
- sel_b  input  1  operand-2 select: 0 = rd_data2, 1 = imm_in
- pc_in  input  WIDTH  program counter value
- imm_in  input  WIDTH  sign-extended immediate
- alu_op  input  4  ALU operation code
- alu_en  input  1  capture ALU result and flags
- alu_out  output  WIDTH  registered ALU result
- zero_flag  output  1  registered: alu_out == 0
- carry_flag  output  1  registered carry/borrow

## Operation
- Register bank: 16 entries. All entries are general-purpose and writable; R0 is not hardwired.
- Write: on a clk edge with wr_en=1, reg[wr_addr] <= wr_data.
- Read: on a clk edge with rd_enN=1, rd_dataN <= reg[rd_addrN]. With rd_enN=0, rd_dataN holds its value.
- Operand multiplexers are combinational:
  - op1 = sel_a ? pc_in : rd_data1
  - op2 = sel_b ? imm_in : rd_data2
- ALU (combinational core; result registered when alu_en=1). All arithmetic is modulo 2^WIDTH.
  - 0 ADD op1+op2
  - 1 SUB op1-op2
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT op1
  - 6 SLA: op1 << op2[4:0]
  - 7 SRA: arithmetic op1 >>> op2[4:0]
  - 8 SRL: logical op1 >> op2[4:0]
  - 9 INC op1+1
  - 10 DEC op1-1
  - 11 HAM: population count of op1, zero-extended
  - 12–15 reserved: result 0
- carry_flag:
  - ADD/INC: bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB/DEC: 1 when op1 < subtrahend (unsigned borrow).
  - All other ops: 0.
- zero_flag is computed from the captured result.

## Timing
- Reset (async, immediate): all 16 registers, rd_data1/2, alu_out, zero_flag = 0; carry_flag = 0.
- Read latency: 1 cycle (address at edge N, data valid after edge N).
- ALU latency: 1 cycle from operands/alu_op to alu_out/flags.
- Register read to ALU result: 2 edges.
- Both read ports may access the same address in the same cycle; both return the same value.
- Simultaneous read and write to the same address:
  - With bypass enabled (see Configuration): the read returns wr_data.
  - Otherwise: the read returns the old contents.
- Reset asserted mid-sequence clears everything. The first edge after deassertion behaves normally.
- alu_en=0: alu_out and flags hold their values.

## Configuration
- RF_BYPASS_EN defined: write-first forwarding. A read of wr_addr in the same edge as a write returns wr_data.
- RF_BYPASS_EN undefined: read-first. A same-edge read returns the pre-write value; the new value is visible from the next read.

## Test plan
- Reset: write R3=0x1234, then pulse rst asynchronously between edges → rd_data1, alu_out, flags read 0 immediately, and a subsequent read of R3 returns 0.
- Write/read: write R5=0x0000_00FF and R6=0x0000_0001. Read R5 on port 1 and R6 on port 2; ADD with sel_a=0, sel_b=0 → alu_out=0x100, zero=0, carry=0.
- Immediate/PC path: pc_in=0x40, imm_in=0xFFFF_FFF0 (−16), sel_a=1, sel_b=1, ADD → alu_out=0x30, carry=1.
- SUB borrow/zero: op1=5, op2=5 → 0, zero=1, carry=0. Then op1=3, op2=5 → 0xFFFF_FFFE, carry=1.
- Shifts and HAM:
  - SRA on 0x8000_0000 by 4 → 0xF800_0000.
  - SRL → 0x0800_0000.
  - HAM of 0xF0F0_0001 → 9.
  - Reserved op 13 → 0, zero=1.
- Same-address read during write of R7=0xDEAD_BEEF (old value 0): read R7 on that edge → 0xDEAD_BEEF with RF_BYPASS_EN, 0 without. The next read returns 0xDEAD_BEEF in both builds.
